// File: rtl/bus_arbiter.sv
// bus_arbiter: merges the fetch and load/store ports onto one bus master.
// One transfer in flight at a time; the data phase is guarded by a timeout.
module bus_arbiter #(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [31:0] i_address,
    output logic        i_done,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic        d_valid,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        m_start,
    output logic        m_write,
    output logic [31:0] m_address,
    output logic [31:0] m_write_data,
    input  logic [31:0] m_read_data,
    input  logic        m_response,
    input  logic        m_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam logic PORT_I     = 1'b0;
    localparam logic PORT_D     = 1'b1;
    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;
    // TIMEOUT is limited to 256 so the final count fits the 8-bit counter
    localparam logic [7:0] CNT_LAST =
        8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t      r_state;
    logic        r_owner;
    logic        r_last;
    logic [7:0]  r_cnt;
    logic        r_i_done;
    logic [31:0] r_i_rdata;
    logic        r_i_resp;
    logic        r_d_done;
    logic [31:0] r_d_rdata;
    logic        r_d_resp;
    logic        r_m_start;
    logic        r_m_write;
    logic [31:0] r_m_address;
    logic [31:0] r_m_wdata;

    logic        w_any;
    logic        w_pick;
    logic        w_timeout;
    logic        w_finish;
    logic [31:0] w_rdata;
    logic        w_resp;

    // Pick the winner and decode how the data phase ends
    always_comb begin
        w_any  = i_valid | d_valid;
        w_pick = d_valid ? PORT_D : PORT_I;
        if (i_valid && d_valid) begin
            w_pick = ROUND_ROBIN ? ~r_last : PORT_D;
        end
        w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
        w_finish  = m_ready | w_timeout;
        w_rdata   = m_ready ? m_read_data : 32'd0;
        w_resp    = m_ready ? m_response : RESP_ERROR;
    end

    // Transfer sequencer: IDLE grants, ADDR strobes start, DATA waits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= PORT_I;
            r_last      <= PORT_D;
            r_cnt       <= 8'd0;
            r_i_done    <= 1'b0;
            r_i_rdata   <= 32'd0;
            r_i_resp    <= RESP_OKAY;
            r_d_done    <= 1'b0;
            r_d_rdata   <= 32'd0;
            r_d_resp    <= RESP_OKAY;
            r_m_start   <= 1'b0;
            r_m_write   <= 1'b0;
            r_m_address <= 32'd0;
            r_m_wdata   <= 32'd0;
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner   <= w_pick;
                        r_last    <= w_pick;
                        r_m_start <= 1'b1;
                        r_state   <= S_ADDR;
                        if (w_pick == PORT_D) begin
                            r_m_write   <= d_write;
                            r_m_address <= d_address;
                            r_m_wdata   <= d_write ? d_wdata : 32'd0;
                        end else begin
                            r_m_write   <= 1'b0;
                            r_m_address <= i_address;
                            r_m_wdata   <= 32'd0;
                        end
                    end
                end
                S_ADDR: begin
                    r_m_start <= 1'b0;
                    r_cnt     <= 8'd0;
                    r_state   <= S_DATA;
                end
                S_DATA: begin
                    if (w_finish) begin
                        r_state <= S_IDLE;
                        if (r_owner == PORT_D) begin
                            r_d_done  <= 1'b1;
                            r_d_rdata <= w_rdata;
                            r_d_resp  <= w_resp;
                        end else begin
                            r_i_done  <= 1'b1;
                            r_i_rdata <= w_rdata;
                            r_i_resp  <= w_resp;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign i_done       = r_i_done;
    assign i_rdata      = r_i_rdata;
    assign i_resp       = r_i_resp;
    assign d_done       = r_d_done;
    assign d_rdata      = r_d_rdata;
    assign d_resp       = r_d_resp;
    assign m_start      = r_m_start;
    assign m_write      = r_m_write;
    assign m_address    = r_m_address;
    assign m_write_data = r_m_wdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: two arbiter configurations (round robin / fixed priority)
// against a timeline model, plus directed literal checks.
module tb_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit fin [2];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam bit RR = (g == 0);
        localparam int TO = (g == 0) ? 8 : 4;

        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic        idn;
        logic [31:0] ird;
        logic        irs;
        logic        dv;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        ddn;
        logic [31:0] drd;
        logic        drs;
        logic        ms;
        logic        mw;
        logic [31:0] ma;
        logic [31:0] mwd;
        logic [31:0] mrd;
        logic        mrs;
        logic        mrdy;
        int          sl_wait;
        logic [31:0] sl_rd;
        logic        sl_rs;

        bus_arbiter #(.ROUND_ROBIN(RR), .TIMEOUT(TO)) u_dut (
            .clk(clk), .rst(rst),
            .i_valid(iv), .i_address(ia), .i_done(idn),
            .i_rdata(ird), .i_resp(irs),
            .d_valid(dv), .d_write(dw), .d_address(da), .d_wdata(dwd),
            .d_done(ddn), .d_rdata(drd), .d_resp(drs),
            .m_start(ms), .m_write(mw), .m_address(ma),
            .m_write_data(mwd), .m_read_data(mrd),
            .m_response(mrs), .m_ready(mrdy)
        );

        // Slave: after each start, wait sl_wait DATA cycles (random if < 0)
        initial begin : slave
            int cd;
            bit rnd;
            cd = -1;
            rnd = 1'b0;
            mrdy = 1'b0;
            mrd = 32'd0;
            mrs = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                mrdy = 1'b0;
                mrd = $urandom;
                mrs = 1'($urandom_range(0, 1));
                if (ms) begin
                    rnd = (sl_wait < 0);
                    cd = rnd ? int'($urandom_range(0, TO + 2)) : sl_wait;
                end else if (cd == 0) begin
                    mrdy = 1'b1;
                    mrd = rnd ? $urandom : sl_rd;
                    mrs = rnd ? ($urandom_range(0, 3) == 0) : sl_rs;
                    cd = -1;
                end else if (cd > 0) begin
                    cd--;
                end
            end
        end

        // Timeline model: grant at edge G, start after G, done after the
        // first ready edge >= G+2 or at G+1+TO; compared every cycle
        initial begin : model
            int e, gt, el;
            bit busy, own, last;
            logic e_ms, e_mw, e_id, e_dd, e_irs, e_drs;
            logic [31:0] e_ma, e_mwd, e_ird, e_drd;
            e = 0; gt = 0; el = 0;
            busy = 1'b0; own = 1'b0; last = 1'b1;
            e_ms = 0; e_mw = 0; e_id = 0; e_dd = 0; e_irs = 0; e_drs = 0;
            e_ma = 0; e_mwd = 0; e_ird = 0; e_drd = 0;
            forever begin
                @(posedge clk);
                e++;
                e_ms = 1'b0;
                e_id = 1'b0;
                e_dd = 1'b0;
                if (rst) begin
                    busy = 1'b0; last = 1'b1;
                    e_mw = 0; e_ma = 0; e_mwd = 0;
                    e_ird = 0; e_irs = 0; e_drd = 0; e_drs = 0;
                end else if (!busy) begin
                    if (iv || dv) begin
                        own = (iv && dv) ? (RR ? !last : 1'b1) : dv;
                        last = own;
                        busy = 1'b1;
                        gt = e;
                        e_ms = 1'b1;
                        e_mw = own & dw;
                        e_ma = own ? da : ia;
                        e_mwd = (own && dw) ? dwd : 32'd0;
                    end
                end else begin
                    el = e - gt;
                    if (el >= 2 && (mrdy || (TO != 0 && el - 1 == TO))) begin
                        busy = 1'b0;
                        if (own) begin
                            e_dd = 1'b1;
                            e_drd = mrdy ? mrd : 32'd0;
                            e_drs = mrdy ? mrs : 1'b1;
                        end else begin
                            e_id = 1'b1;
                            e_ird = mrdy ? mrd : 32'd0;
                            e_irs = mrdy ? mrs : 1'b1;
                        end
                    end
                end
                @(negedge clk);
                chk($sformatf("cfg%0d m_start", g), 32'(ms), 32'(e_ms));
                chk($sformatf("cfg%0d m_write", g), 32'(mw), 32'(e_mw));
                chk($sformatf("cfg%0d m_address", g), ma, e_ma);
                chk($sformatf("cfg%0d m_write_data", g), mwd, e_mwd);
                chk($sformatf("cfg%0d i_done", g), 32'(idn), 32'(e_id));
                chk($sformatf("cfg%0d i_rdata", g), ird, e_ird);
                chk($sformatf("cfg%0d i_resp", g), 32'(irs), 32'(e_irs));
                chk($sformatf("cfg%0d d_done", g), 32'(ddn), 32'(e_dd));
                chk($sformatf("cfg%0d d_rdata", g), drd, e_drd);
                chk($sformatf("cfg%0d d_resp", g), 32'(drs), 32'(e_drs));
            end
        end

        task automatic freq(input logic [31:0] a, output int lat);
            iv = 1'b1;
            ia = a;
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
            end while (!idn && lat < 400);
            chk($sformatf("cfg%0d fetch_completes", g), 32'(idn), 32'd1);
            iv = 1'b0;
        endtask

        task automatic dreq(input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, output int lat);
            dv = 1'b1;
            dw = wr;
            da = a;
            dwd = wd;
            lat = 0;
            do begin
                @(posedge clk);
                #1;
                lat++;
            end while (!ddn && lat < 400);
            chk($sformatf("cfg%0d data_completes", g), 32'(ddn), 32'd1);
            dv = 1'b0;
        endtask

        // Directed scenarios followed by random traffic
        initial begin : drv
            int lf[3];
            int ld[3];
            int l0;
            rst = 1'b1;
            iv = 1'b0; ia = 32'd0;
            dv = 1'b0; dw = 1'b0; da = 32'd0; dwd = 32'd0;
            sl_wait = 0; sl_rd = 32'd0; sl_rs = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            chk($sformatf("cfg%0d rst m_start", g), 32'(ms), 32'd0);
            chk($sformatf("cfg%0d rst m_address", g), ma, 32'd0);
            chk($sformatf("cfg%0d rst d_resp", g), 32'(drs), 32'd0);

            sl_wait = 0;
            sl_rd = 32'hDEAD_BEEF;
            freq(32'h0000_0010, l0);
            chk($sformatf("cfg%0d fetch latency", g), 32'(l0), 32'd3);
            chk($sformatf("cfg%0d fetch rdata", g), ird, 32'hDEAD_BEEF);
            chk($sformatf("cfg%0d fetch resp", g), 32'(irs), 32'd0);
            chk($sformatf("cfg%0d fetch addr", g), ma, 32'h0000_0010);

            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            sl_rd = 32'h1111_2222;
            fork
                for (int k = 0; k < 3; k++) freq(32'h40 + 32'(k), lf[k]);
                for (int k = 0; k < 3; k++)
                    dreq(1'b0, 32'h80 + 32'(k), 32'hFFFF_FFFF, ld[k]);
            join
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("cfg%0d contend fetch lat %0d", g, k), 32'(lf[k]),
                    32'(RR ? ((k == 0) ? 3 : 6) : ((k == 0) ? 12 : 3)));
                chk($sformatf("cfg%0d contend data lat %0d", g, k), 32'(ld[k]),
                    32'(RR ? 6 : 3));
            end

            sl_wait = 5;
            sl_rd = 32'hA5A5_A5A5;
            sl_rs = 1'b0;
            dreq(1'b1, 32'h100, 32'h1234_5678, l0);
            chk($sformatf("cfg%0d write lat", g), 32'(l0),
                32'((5 < TO) ? 8 : TO + 2));
            chk($sformatf("cfg%0d write resp", g), 32'(drs),
                32'((5 < TO) ? 0 : 1));
            chk($sformatf("cfg%0d write m_write", g), 32'(mw), 32'd1);
            chk($sformatf("cfg%0d write m_address", g), ma, 32'h100);
            chk($sformatf("cfg%0d write m_wdata", g), mwd, 32'h1234_5678);

            sl_wait = 1000;
            dreq(1'b0, 32'h200, 32'h5555_5555, l0);
            chk($sformatf("cfg%0d timeout lat", g), 32'(l0), 32'(TO + 2));
            chk($sformatf("cfg%0d timeout resp", g), 32'(drs), 32'd1);
            chk($sformatf("cfg%0d timeout rdata", g), drd, 32'd0);
            chk($sformatf("cfg%0d timeout m_wdata", g), mwd, 32'd0);

            fork
                dreq(1'b0, 32'h300, 32'hCAFE_F00D, ld[0]);
                begin
                    @(posedge clk);
                    @(posedge clk);
                    #2;
                    rst = 1'b1;
                    sl_wait = 0;
                    sl_rd = 32'h0BAD_F00D;
                    @(posedge clk);
                    #2;
                    chk($sformatf("cfg%0d midrst m_start", g), 32'(ms), 32'd0);
                    chk($sformatf("cfg%0d midrst m_addr", g), ma, 32'd0);
                    chk($sformatf("cfg%0d midrst d_done", g), 32'(ddn), 32'd0);
                    chk($sformatf("cfg%0d midrst d_resp", g), 32'(drs), 32'd0);
                    chk($sformatf("cfg%0d midrst i_rdata", g), ird, 32'd0);
                    rst = 1'b0;
                end
            join
            chk($sformatf("cfg%0d after rst rdata", g), drd, 32'h0BAD_F00D);
            chk($sformatf("cfg%0d after rst resp", g), 32'(drs), 32'd0);

            sl_wait = -1;
            fork
                for (int k = 0; k < 40; k++) begin
                    int l;
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    freq($urandom & 32'hFFFF_FFFC, l);
                end
                for (int k = 0; k < 40; k++) begin
                    int l;
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    dreq(1'($urandom_range(0, 1)), $urandom, $urandom, l);
                end
            join
            repeat (5) @(posedge clk);
            fin[g] = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 30000 && !(fin[0] && fin[1]); c++) begin
            @(posedge clk);
        end
        n_cmp++;
        if (!(fin[0] && fin[1])) begin
            n_bad++;
            $display("FAIL run_bound: got fin=%0d%0d expected 11", fin[0], fin[1]);
        end
        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
